// File: rtl/me266_host_pkg.sv
// rtl/me266_host_pkg.sv - shared widths, RX state encoding and result type for the me266 host interface
package me266_host_pkg;

  localparam int SAD_WIDTH = 16;
  localparam int MV_WIDTH  = 6;
  localparam int REF_DW    = 64;
  localparam int CUR_DW    = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    DONE = 2'd2
  } rx_state_t;

  typedef struct packed {
    logic [SAD_WIDTH-1:0] sad;
    logic [MV_WIDTH-1:0]  mvx;
    logic [MV_WIDTH-1:0]  mvy;
  } res_t;

endpackage

// File: rtl/me266_res_rx.sv
// rtl/me266_res_rx.sv - serial SAD/MV result deserialiser (start bit, MSB-first data, one DONE cycle)
module me266_res_rx
  import me266_host_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic sad_out,
  input  logic x_out,
  input  logic y_out,
  output logic res_valid,
  output res_t res
);

  localparam int CNT_W = $clog2(SAD_WIDTH);

  rx_state_t            state, state_nx;
  logic [CNT_W-1:0]     bit_cnt;
  logic [SAD_WIDTH-1:0] sad_sr, sad_nx;
  logic [MV_WIDTH-1:0]  mvx_sr, mvy_sr, mvx_nx, mvy_nx;
  logic                 last_bit, mv_bit;

  assign last_bit = (bit_cnt == CNT_W'(SAD_WIDTH - 1));
  // one extra bit so the comparison stays valid even when MV_WIDTH == SAD_WIDTH
  assign mv_bit   = ({1'b0, bit_cnt} < (CNT_W + 1)'(MV_WIDTH));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    res_valid = 1'b0;
    sad_nx    = {sad_sr[SAD_WIDTH-2:0], sad_out};
    mvx_nx    = mv_bit ? {mvx_sr[MV_WIDTH-2:0], x_out} : mvx_sr;
    mvy_nx    = mv_bit ? {mvy_sr[MV_WIDTH-2:0], y_out} : mvy_sr;
    case (state)
      IDLE:    if (sad_out) state_nx = DATA;
      DATA:    if (last_bit) state_nx = DONE;
      DONE: begin
        res_valid = 1'b1;
        state_nx  = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // The result register is loaded with the last bit so it is already stable in DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt <= '0;
      sad_sr  <= '0;
      mvx_sr  <= '0;
      mvy_sr  <= '0;
      res     <= '0;
    end else if (state == DATA) begin
      sad_sr  <= sad_nx;
      mvx_sr  <= mvx_nx;
      mvy_sr  <= mvy_nx;
      bit_cnt <= last_bit ? '0 : bit_cnt + CNT_W'(1);
      if (last_bit) res <= '{sad: sad_nx, mvx: mvx_nx, mvy: mvy_nx};
    end else begin
      bit_cnt <= '0;
    end
  end

endmodule

// File: rtl/me266_host_if.sv
// rtl/me266_host_if.sv - me266 board-side fetch channels and result receiver; ME266_HOST_STAT_EN adds saturating request/result counters
module me266_host_if
  import me266_host_pkg::*;
#(
  parameter int REF_AW    = 16,
  parameter int CUR_AW    = 16,
  parameter int REF_WORDS = 288,
  parameter int CUR_WORDS = 64,
  parameter int SAD_W     = SAD_WIDTH,
  parameter int MV_W      = MV_WIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              blk_start,
  input  logic [REF_AW-1:0] ref_base,
  input  logic [CUR_AW-1:0] cur_base,
  input  logic              ref_read,
  input  logic              cur_read,
  output logic [REF_DW-1:0] ref_in,
  output logic [CUR_DW-1:0] cur_in,
  output logic [REF_AW-1:0] ref_addr,
  input  logic [REF_DW-1:0] ref_rdata,
  output logic [CUR_AW-1:0] cur_addr,
  input  logic [CUR_DW-1:0] cur_rdata,
  input  logic              sad_out,
  input  logic              x_out,
  input  logic              y_out,
  output logic              res_valid,
  output logic [SAD_W-1:0]  res_sad,
  output logic [MV_W-1:0]   res_mvx,
  output logic [MV_W-1:0]   res_mvy,
  output logic              ref_done,
  output logic              cur_done
`ifdef ME266_HOST_STAT_EN
  ,
  output logic [15:0]       stat_frames,
  output logic [15:0]       stat_ref_reqs,
  output logic [15:0]       stat_cur_reqs
`endif
);

  localparam int REF_OW = $clog2(REF_WORDS);
  localparam int CUR_OW = $clog2(CUR_WORDS);

  logic [REF_AW-1:0] ref_base_q;
  logic [REF_OW-1:0] ref_off, ref_off_use;
  logic              ref_v1, ref_v2, ref_l1, ref_l2, ref_last;
  logic [CUR_AW-1:0] cur_base_q;
  logic [CUR_OW-1:0] cur_off, cur_off_use;
  logic              cur_v1, cur_v2, cur_l1, cur_l2, cur_last;
  res_t              rx_res;

  // blk_start wins the offset so a same-cycle request fetches word 0 of the new block
  assign ref_off_use = blk_start ? '0 : ref_off;
  assign cur_off_use = blk_start ? '0 : cur_off;
  assign ref_last    = (ref_off_use == REF_OW'(REF_WORDS - 1));
  assign cur_last    = (cur_off_use == CUR_OW'(CUR_WORDS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      ref_base_q <= '0;
      ref_off    <= '0;
      ref_addr   <= '0;
      ref_in     <= '0;
      ref_done   <= 1'b0;
      ref_v1     <= 1'b0;
      ref_v2     <= 1'b0;
      ref_l1     <= 1'b0;
      ref_l2     <= 1'b0;
    end else begin
      if (blk_start) ref_base_q <= ref_base;
      ref_v1   <= ref_read;
      ref_l1   <= ref_read && ref_last;
      ref_v2   <= ref_v1;
      ref_l2   <= ref_l1;
      ref_done <= ref_v2 && ref_l2;
      if (ref_v2) ref_in <= ref_rdata;
      if (ref_read) begin
        ref_addr <= (blk_start ? ref_base : ref_base_q) + REF_AW'(ref_off_use);
        ref_off  <= ref_last ? '0 : ref_off_use + REF_OW'(1);
      end else if (blk_start) begin
        ref_off  <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_base_q <= '0;
      cur_off    <= '0;
      cur_addr   <= '0;
      cur_in     <= '0;
      cur_done   <= 1'b0;
      cur_v1     <= 1'b0;
      cur_v2     <= 1'b0;
      cur_l1     <= 1'b0;
      cur_l2     <= 1'b0;
    end else begin
      if (blk_start) cur_base_q <= cur_base;
      cur_v1   <= cur_read;
      cur_l1   <= cur_read && cur_last;
      cur_v2   <= cur_v1;
      cur_l2   <= cur_l1;
      cur_done <= cur_v2 && cur_l2;
      if (cur_v2) cur_in <= cur_rdata;
      if (cur_read) begin
        cur_addr <= (blk_start ? cur_base : cur_base_q) + CUR_AW'(cur_off_use);
        cur_off  <= cur_last ? '0 : cur_off_use + CUR_OW'(1);
      end else if (blk_start) begin
        cur_off  <= '0;
      end
    end
  end

  me266_res_rx u_res_rx (
    .clk       (clk),
    .rst       (rst),
    .sad_out   (sad_out),
    .x_out     (x_out),
    .y_out     (y_out),
    .res_valid (res_valid),
    .res       (rx_res)
  );

  assign res_sad = SAD_W'(rx_res.sad);
  assign res_mvx = MV_W'(rx_res.mvx);
  assign res_mvy = MV_W'(rx_res.mvy);

`ifdef ME266_HOST_STAT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_frames   <= '0;
      stat_ref_reqs <= '0;
      stat_cur_reqs <= '0;
    end else begin
      if (res_valid && stat_frames != 16'hFFFF)   stat_frames   <= stat_frames + 16'd1;
      if (ref_read && stat_ref_reqs != 16'hFFFF)  stat_ref_reqs <= stat_ref_reqs + 16'd1;
      if (cur_read && stat_cur_reqs != 16'hFFFF)  stat_cur_reqs <= stat_cur_reqs + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_me266_host_if.sv
// tb/tb_me266_host_if.sv - self-checking bench for me266_host_if against a queue-based reference model
module tb_me266_host_if;

  localparam int REF_WORDS = 288;
  localparam int CUR_WORDS = 64;

  logic        clk = 1'b0;
  logic        rst, blk_start, ref_read, cur_read, sad_out, x_out, y_out;
  logic [15:0] ref_base, cur_base, ref_addr, cur_addr;
  logic [63:0] ref_in, ref_rdata;
  logic [31:0] cur_in, cur_rdata;
  logic        res_valid, ref_done, cur_done;
  logic [15:0] res_sad;
  logic [5:0]  res_mvx, res_mvy;
`ifdef ME266_HOST_STAT_EN
  logic [15:0] stat_frames, stat_ref_reqs, stat_cur_reqs;
`endif

  always #5 clk = ~clk;

  me266_host_if dut (
    .clk(clk), .rst(rst), .blk_start(blk_start), .ref_base(ref_base), .cur_base(cur_base),
    .ref_read(ref_read), .cur_read(cur_read), .ref_in(ref_in), .cur_in(cur_in),
    .ref_addr(ref_addr), .ref_rdata(ref_rdata), .cur_addr(cur_addr), .cur_rdata(cur_rdata),
    .sad_out(sad_out), .x_out(x_out), .y_out(y_out), .res_valid(res_valid),
    .res_sad(res_sad), .res_mvx(res_mvx), .res_mvy(res_mvy),
    .ref_done(ref_done), .cur_done(cur_done)
`ifdef ME266_HOST_STAT_EN
    , .stat_frames(stat_frames), .stat_ref_reqs(stat_ref_reqs), .stat_cur_reqs(stat_cur_reqs)
`endif
  );

  function automatic logic [63:0] ref_f(input logic [15:0] a);
    return {a, ~a, a ^ 16'hA5C3, a + 16'h1357};
  endfunction

  function automatic logic [31:0] cur_f(input logic [15:0] a);
    return {a ^ 16'h0F0F, a + 16'h2468};
  endfunction

  // frame memories with one cycle of read latency
  always @(posedge clk) begin
    ref_rdata <= ref_f(ref_addr);
    cur_rdata <= cur_f(cur_addr);
  end

  typedef struct {
    int          due;
    bit          last;
    logic [15:0] addr;
  } fetch_t;

  fetch_t      rq[$], cq[$];
  logic [3:0]  tx_q[$];
  logic [27:0] fr_q[$];
  logic [27:0] pend, hold;
  logic [15:0] rbase, cbase, raddr_m, caddr_m;
  logic [63:0] rin_m;
  logic [31:0] cin_m;
  int          rn, cn, cyc, exp_vcyc;
  int          n_frames, n_rreq, n_creq;
  int          checks, errors;
  int          rdone_cnt, cdone_cnt;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic send_frame(input logic [15:0] s, input logic [5:0] mx, input logic [5:0] my,
                            input bit gap_hi);
    fr_q.push_back({s, mx, my});
    tx_q.push_back({1'b1, 1'b1, 1'($urandom), 1'($urandom)});
    for (int k = 0; k < 16; k++)
      tx_q.push_back({1'b0, s[15-k],
                      (k < 6) ? mx[5-k] : 1'($urandom),
                      (k < 6) ? my[5-k] : 1'($urandom)});
    tx_q.push_back({1'b0, gap_hi, 1'($urandom), 1'($urandom)});
  endtask

  // One clock: drive serial lines, advance the model on the sampled inputs, compare outputs.
  task automatic step();
    logic       rr, cr, bs, rs;
    logic [3:0] e;
    fetch_t     f;
    bit         rdone_e, cdone_e;
    rs = rst; bs = blk_start; rr = ref_read; cr = cur_read;
    e = {2'b00, 1'($urandom), 1'($urandom)};
    if (rs) begin
      tx_q.delete();
      fr_q.delete();
    end else if (tx_q.size() > 0) begin
      e = tx_q.pop_front();
    end
    if (e[3]) begin
      pend     = fr_q.pop_front();
      exp_vcyc = cyc + 17;
    end
    sad_out = e[2]; x_out = e[1]; y_out = e[0];
    @(posedge clk);
    #1;
    cyc++;
    if (rs) begin
      rq.delete(); cq.delete();
      rbase = '0; cbase = '0; rn = 0; cn = 0;
      raddr_m = '0; caddr_m = '0; rin_m = '0; cin_m = '0;
      exp_vcyc = -1; hold = '0;
      n_frames = 0; n_rreq = 0; n_creq = 0;
    end else begin
      if (bs) begin
        rbase = ref_base; cbase = cur_base; rn = 0; cn = 0;
      end
      if (rr) begin
        f.due = cyc + 2; f.last = (rn == REF_WORDS - 1); f.addr = rbase + 16'(rn);
        raddr_m = f.addr; rq.push_back(f);
        rn = (rn + 1) % REF_WORDS; n_rreq++;
      end
      if (cr) begin
        f.due = cyc + 2; f.last = (cn == CUR_WORDS - 1); f.addr = cbase + 16'(cn);
        caddr_m = f.addr; cq.push_back(f);
        cn = (cn + 1) % CUR_WORDS; n_creq++;
      end
    end
    rdone_e = 1'b0;
    if (rq.size() > 0 && rq[0].due == cyc) begin
      f = rq.pop_front(); rin_m = ref_f(f.addr); rdone_e = f.last;
    end
    cdone_e = 1'b0;
    if (cq.size() > 0 && cq[0].due == cyc) begin
      f = cq.pop_front(); cin_m = cur_f(f.addr); cdone_e = f.last;
    end
    if (cyc == exp_vcyc) begin
      hold = pend; n_frames++;
    end
    chk("ref_addr", ref_addr, raddr_m);
    chk("ref_in", ref_in, rin_m);
    chk("ref_done", ref_done, rdone_e);
    chk("cur_addr", cur_addr, caddr_m);
    chk("cur_in", cur_in, cin_m);
    chk("cur_done", cur_done, cdone_e);
    chk("res_valid", res_valid, cyc == exp_vcyc);
    chk("res_sad", res_sad, hold[27:12]);
    chk("res_mvx", res_mvx, hold[11:6]);
    chk("res_mvy", res_mvy, hold[5:0]);
    if (ref_done) rdone_cnt++;
    if (cur_done) cdone_cnt++;
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && tx_q.size() > 0; i++) step();
    repeat (3) step();
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0; exp_vcyc = -1;
    rst = 1'b1; blk_start = 1'b0; ref_read = 1'b0; cur_read = 1'b0;
    ref_base = '0; cur_base = '0; sad_out = 1'b0; x_out = 1'b0; y_out = 1'b0;
    repeat (3) step();
    chk("reset_ref_addr", ref_addr, 16'h0000);
    chk("reset_ref_in", ref_in, 64'h0);
    chk("reset_res_valid", res_valid, 1'b0);
    rst = 1'b0;
    step();

    // single requests at the start of a block
    blk_start = 1'b1; ref_base = 16'h0100; cur_base = 16'h0040;
    step();
    blk_start = 1'b0;
    ref_read = 1'b1; step(); ref_read = 1'b0;
    chk("ref_addr_first", ref_addr, 16'h0100);
    step(); step();
    chk("ref_in_first", ref_in, ref_f(16'h0100));
    ref_read = 1'b1; step(); ref_read = 1'b0;
    chk("ref_addr_off1", ref_addr, 16'h0101);
    repeat (3) step();

    // full window, both streams every cycle, wrap on the 289th request
    blk_start = 1'b1; step(); blk_start = 1'b0;
    rdone_cnt = 0; cdone_cnt = 0;
    ref_read = 1'b1; cur_read = 1'b1;
    for (int i = 0; i < 289; i++) begin
      step();
      if (i == 287) chk("ref_addr_last", ref_addr, 16'h021F);
      if (i == 288) chk("ref_addr_wrap", ref_addr, 16'h0100);
      if (i == 63)  chk("cur_addr_last", cur_addr, 16'h007F);
      if (i == 64)  chk("cur_addr_wrap", cur_addr, 16'h0040);
    end
    ref_read = 1'b0; cur_read = 1'b0;
    repeat (3) step();
    chk("ref_done_count", rdone_cnt, 1);
    chk("cur_done_count", cdone_cnt, 4);

    // random fetch traffic with block restarts and random result frames
    for (int i = 0; i < 600; i++) begin
      ref_read = 1'($urandom); cur_read = 1'($urandom);
      blk_start = ($urandom_range(0, 39) == 0);
      ref_base = ($urandom_range(0, 1) == 1) ? 16'hFFF0 + 16'($urandom_range(0, 15)) : 16'($urandom);
      cur_base = 16'($urandom);
      if (tx_q.size() == 0 && $urandom_range(0, 3) == 0)
        send_frame(16'($urandom), 6'($urandom), 6'($urandom), 1'($urandom));
      step();
    end
    ref_read = 1'b0; cur_read = 1'b0; blk_start = 1'b0;
    drain();

    // back-to-back frames; the gap cycle carries a high sad_out that must be ignored
    send_frame(16'h1234, 6'h3D, 6'h05, 1'b1);
    send_frame(16'hBEEF, 6'h10, 6'h2F, 1'b0);
    for (int i = 0; i < 19; i++) step();
    chk("frame1_sad", res_sad, 16'h1234);
    chk("frame1_mvx", res_mvx, 6'h3D);
    chk("frame1_mvy", res_mvy, 6'h05);
    drain();
    chk("frame2_sad", res_sad, 16'hBEEF);
    chk("frame2_mvx", res_mvx, 6'h10);

    // reset during data bit 7 discards the frame
    send_frame(16'hA5A5, 6'h21, 6'h1E, 1'b0);
    repeat (8) step();
    rst = 1'b1; step(); rst = 1'b0;
    repeat (20) step();
    chk("rst_mid_sad", res_sad, 16'h0000);
    chk("rst_mid_mvx", res_mvx, 6'h00);
    send_frame(16'h0F0F, 6'h3F, 6'h01, 1'b0);
    drain();
    chk("after_rst_sad", res_sad, 16'h0F0F);
    chk("after_rst_mvy", res_mvy, 6'h01);

`ifdef ME266_HOST_STAT_EN
    rst = 1'b1; step(); rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      ref_read = 1'b1; cur_read = (i < 4);
      step();
    end
    ref_read = 1'b0; cur_read = 1'b0;
    send_frame(16'h0001, 6'h01, 6'h02, 1'b0);
    send_frame(16'h0002, 6'h03, 6'h04, 1'b0);
    send_frame(16'h0003, 6'h05, 6'h06, 1'b0);
    drain();
    chk("stat_frames", stat_frames, 16'd3);
    chk("stat_ref_reqs", stat_ref_reqs, 16'd10);
    chk("stat_cur_reqs", stat_cur_reqs, 16'd4);
    chk("stat_frames_model", stat_frames, 16'(n_frames));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
